i2c_config_sequencer: RTL and testbench
=======================================

Name: i2c_config_sequencer

Overview:
Walks a table of 24-bit I2C write commands ({slave address, register address, data}) and issues them one at a time to the I2C write master. It sequences the HDMI transmitter's power-up register configuration. It handles ACK errors with bounded retries, a per-transaction timeout and an inter-write gap. It sits between the top-level bring-up logic and the I2C interface, and reads the command table from an external synchronous ROM.

Parameters:
NUM_ENTRIES, 32, number of table entries; legal range 1..256
ADDR_WIDTH, 8, ROM address width; 2**ADDR_WIDTH >= NUM_ENTRIES
MAX_RETRIES, 3, re-issues of one entry after NACK or timeout before declaring error
GAP_CYCLES, 100, idle clocks between consecutive transactions (0 allowed)
TIMEOUT_CYCLES, 65535, clocks in WAIT before the transaction counts as failed

Ports:
clock50M  in  1  system clock, 50 MHz, all logic on rising edge
reset  in  1  synchronous active-high reset
configStart  in  1  level; sampled in IDLE/DONE/ERROR, starts a sequence from entry 0
romAddr  out  ADDR_WIDTH  table index
romData  in  24  table word, valid 1 clock after romAddr
i2cStart  out  1  one-clock pulse, launches a transaction with i2cData
i2cData  out  24  {slave[23:16], reg[15:8], data[7:0]}, stable from ISSUE until the next FETCH
i2cDone  in  1  one-clock pulse from master, transaction finished
i2cAckError  in  1  valid with i2cDone; 1 = a NACK was received
busy  out  1  high in FETCH/LATCH/ISSUE/WAIT/GAP
configDone  out  1  high in DONE
configError  out  1  high in ERROR
errorIndex  out  ADDR_WIDTH  index of the entry that exhausted its retries

Behaviour:
- Clock and reset: one clock, clock50M; reset is synchronous and active-high, named reset.
- Reset values: state=IDLE, romAddr=0, i2cStart=0, i2cData=0, busy=0, configDone=0, configError=0, errorIndex=0, retry count=0, counters=0.
- Reset mid-operation: abort immediately. i2cStart is low on the next clock. Nothing is resumed.
- IDLE: if configStart=1, index:=0 and go to FETCH.
- FETCH (1 clk): romAddr=index. Go to LATCH.
- LATCH (1 clk): i2cData:=romData.
  - If romData[23:16]=8'hFF (end marker), go to DONE.
  - Otherwise go to ISSUE.
- ISSUE (1 clk): i2cStart=1. Clear the timeout counter. Go to WAIT.
- WAIT: the timeout counter increments each clock.
  - On i2cDone=1 with i2cAckError=0: index++, retry count:=0, go to GAP.
  - On i2cDone=1 with i2cAckError=1, or on timeout counter = TIMEOUT_CYCLES-1:
    - If retry count < MAX_RETRIES: retry count++, go to GAP with the index unchanged.
    - Otherwise: errorIndex:=index, go to ERROR.
  - i2cDone takes priority over timeout when both occur in the same clock.
- GAP: count GAP_CYCLES clocks, then:
  - go to DONE if index = NUM_ENTRIES;
  - otherwise go to FETCH.
  - With GAP_CYCLES=0, GAP lasts 1 clock.
- DONE / ERROR: hold their flag. configStart=1 clears the flag, index:=0 and goes to FETCH.
- Latency: configStart sampled to the first i2cStart is 3 clocks (FETCH, LATCH, ISSUE).
- Ignored inputs:
  - i2cDone outside WAIT.
  - configStart while busy=1.
- Index width is ADDR_WIDTH+1 internally, so index=NUM_ENTRIES=2**ADDR_WIDTH does not wrap.
- romAddr uses the low ADDR_WIDTH bits of the index.
- Retry count is reset per entry, not per sequence.

Optional Feature:
Macro I2C_CONFIG_HPD_REINIT_EN.
- Defined: adds input port hotPlug (1 bit). It is double-flopped internally. A rising edge of the synchronised hotPlug, in any state, forces a restart: state:=FETCH, index:=0, retry count:=0, flags cleared. An in-flight transaction's i2cDone is then ignored. If a configStart restart and a hotPlug restart happen in the same clock, the result is a single restart.
- Undefined: no hotPlug port. Sequencing is triggered only by configStart.

Test Plan:
1. NUM_ENTRIES=3, ROM={72_41_10, 72_98_03, 72_D6_C0}, all ACK: 3 i2cStart pulses with i2cData 0x724110, 0x729803, 0x72D6C0 in order; first pulse 3 clocks after configStart; configDone=1; configError=0.
2. ROM entry 1 = 0xFF0000: only entry 0 issued; configDone=1 one clock after LATCH of entry 1.
3. Entry 1 NACKed twice, then ACKed (MAX_RETRIES=3): i2cData=0x729803 issued 3 times; sequence completes with configDone=1.
4. Entry 2 always NACKed: 4 issues (1+3 retries); configError=1; errorIndex=2; no further i2cStart.
5. Master never returns i2cDone, TIMEOUT_CYCLES=16: retries at 16-clock intervals plus GAP; ERROR after 4 attempts; reset asserted during WAIT gives i2cStart=0, busy=0, and the next configStart restarts from romAddr=0.
6. GAP_CYCLES=100: exactly 101 clocks from i2cDone (ACK) to the next FETCH. Under I2C_CONFIG_HPD_REINIT_EN, hotPlug rising while in DONE: configDone drops and romAddr=0 is fetched within 4 clocks.

Source files
------------

// File: rtl/i2c_config_sequencer_if.sv
// Bus bundle between the I2C configuration sequencer, its command ROM,
// the I2C write master and the bring-up control logic.
interface i2c_config_sequencer_if #(
  parameter int ADDR_WIDTH = 8
);
  logic                  configStart;
  logic [ADDR_WIDTH-1:0] romAddr;
  logic [23:0]           romData;
  logic                  i2cStart;
  logic [23:0]           i2cData;
  logic                  i2cDone;
  logic                  i2cAckError;
  logic                  busy;
  logic                  configDone;
  logic                  configError;
  logic [ADDR_WIDTH-1:0] errorIndex;

  modport master (
    input  configStart, romData, i2cDone, i2cAckError,
    output romAddr, i2cStart, i2cData, busy, configDone, configError, errorIndex
  );

  modport slave (
    output configStart, romData, i2cDone, i2cAckError,
    input  romAddr, i2cStart, i2cData, busy, configDone, configError, errorIndex
  );
endinterface

// File: rtl/i2c_config_sequencer.sv
// Walks a ROM table of {slave, reg, data} I2C writes with retries, timeout and gap.
// Optional I2C_CONFIG_HPD_REINIT_EN adds a hotPlug input that restarts the sequence.
module i2c_config_sequencer #(
  parameter int NUM_ENTRIES    = 32,
  parameter int ADDR_WIDTH     = 8,
  parameter int MAX_RETRIES    = 3,
  parameter int GAP_CYCLES     = 100,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic                  clock50M,
  input  logic                  reset,
`ifdef I2C_CONFIG_HPD_REINIT_EN
  input  logic                  hotPlug,
`endif
  i2c_config_sequencer_if.master bus
);

  localparam int IW           = ADDR_WIDTH + 1;
  localparam int TW           = $clog2(TIMEOUT_CYCLES + 1);
  localparam int GW           = $clog2(GAP_CYCLES + 2);
  localparam int RW           = $clog2(MAX_RETRIES + 2);
  localparam int GAP_LAST_INT = (GAP_CYCLES > 0) ? (GAP_CYCLES - 1) : 0;

  localparam logic [IW-1:0] END_INDEX    = IW'(NUM_ENTRIES);
  localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [GW-1:0] GAP_LAST     = GW'(GAP_LAST_INT);
  localparam logic [RW-1:0] RETRY_LIMIT  = RW'(MAX_RETRIES);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    LATCH = 3'd2,
    ISSUE = 3'd3,
    WAIT  = 3'd4,
    GAP   = 3'd5,
    DONE  = 3'd6,
    ERROR = 3'd7
  } seqState_t;

  seqState_t             state;
  logic [IW-1:0]         index;
  logic [RW-1:0]         retryCount;
  logic [TW-1:0]         timeoutCount;
  logic [GW-1:0]         gapCount;
  logic [ADDR_WIDTH-1:0] romAddrReg;
  logic                  i2cStartReg;
  logic [23:0]           i2cDataReg;
  logic                  busyReg;
  logic                  configDoneReg;
  logic                  configErrorReg;
  logic [ADDR_WIDTH-1:0] errorIndexReg;

  logic hpdRise;
  logic startRequest;
  logic restart;

`ifdef I2C_CONFIG_HPD_REINIT_EN
  logic hotPlugMeta;
  logic hotPlugSync;
  logic hotPlugPrev;

  // Two-flop synchroniser for hotPlug plus a history flop for edge detection.
  always_ff @(posedge clock50M) begin
    if (reset) begin
      hotPlugMeta <= 1'b0;
      hotPlugSync <= 1'b0;
      hotPlugPrev <= 1'b0;
    end else begin
      hotPlugMeta <= hotPlug;
      hotPlugSync <= hotPlugMeta;
      hotPlugPrev <= hotPlugSync;
    end
  end

  assign hpdRise = hotPlugSync & ~hotPlugPrev;
`else
  assign hpdRise = 1'b0;
`endif

  // configStart is only honoured when no sequence is in flight.
  assign startRequest = bus.configStart &
                        ((state == IDLE) | (state == DONE) | (state == ERROR));
  assign restart      = hpdRise | startRequest;

  // Sequencer FSM; every output is registered alongside the state.
  always_ff @(posedge clock50M) begin
    if (reset) begin
      state          <= IDLE;
      index          <= '0;
      retryCount     <= '0;
      timeoutCount   <= '0;
      gapCount       <= '0;
      romAddrReg     <= '0;
      i2cStartReg    <= 1'b0;
      i2cDataReg     <= 24'd0;
      busyReg        <= 1'b0;
      configDoneReg  <= 1'b0;
      configErrorReg <= 1'b0;
      errorIndexReg  <= '0;
    end else begin
      i2cStartReg <= 1'b0;
      if (restart) begin
        // A hotPlug edge and a configStart in the same clock collapse into one restart.
        state          <= FETCH;
        index          <= '0;
        romAddrReg     <= '0;
        retryCount     <= '0;
        timeoutCount   <= '0;
        gapCount       <= '0;
        busyReg        <= 1'b1;
        configDoneReg  <= 1'b0;
        configErrorReg <= 1'b0;
      end else begin
        case (state)
          IDLE, DONE, ERROR: begin
            state <= state;
          end
          FETCH: begin
            state <= LATCH;
          end
          LATCH: begin
            i2cDataReg <= bus.romData;
            if (bus.romData[23:16] == 8'hFF) begin
              state         <= DONE;
              busyReg       <= 1'b0;
              configDoneReg <= 1'b1;
            end else begin
              state       <= ISSUE;
              i2cStartReg <= 1'b1;
            end
          end
          ISSUE: begin
            timeoutCount <= '0;
            state        <= WAIT;
          end
          WAIT: begin
            if (bus.i2cDone && !bus.i2cAckError) begin
              index      <= index + IW'(1);
              retryCount <= '0;
              gapCount   <= '0;
              state      <= GAP;
            end else if (bus.i2cDone || (timeoutCount == TIMEOUT_LAST)) begin
              if (retryCount < RETRY_LIMIT) begin
                retryCount <= retryCount + RW'(1);
                gapCount   <= '0;
                state      <= GAP;
              end else begin
                errorIndexReg  <= index[ADDR_WIDTH-1:0];
                busyReg        <= 1'b0;
                configErrorReg <= 1'b1;
                state          <= ERROR;
              end
            end else begin
              timeoutCount <= timeoutCount + TW'(1);
            end
          end
          GAP: begin
            // GAP_CYCLES of 0 or 1 both leave after a single clock.
            if (gapCount >= GAP_LAST) begin
              if (index == END_INDEX) begin
                busyReg       <= 1'b0;
                configDoneReg <= 1'b1;
                state         <= DONE;
              end else begin
                romAddrReg <= index[ADDR_WIDTH-1:0];
                state      <= FETCH;
              end
            end else begin
              gapCount <= gapCount + GW'(1);
            end
          end
          default: begin
            state          <= IDLE;
            busyReg        <= 1'b0;
            configDoneReg  <= 1'b0;
            configErrorReg <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.romAddr     = romAddrReg;
  assign bus.i2cStart    = i2cStartReg;
  assign bus.i2cData     = i2cDataReg;
  assign bus.busy        = busyReg;
  assign bus.configDone  = configDoneReg;
  assign bus.configError = configErrorReg;
  assign bus.errorIndex  = errorIndexReg;

endmodule

// File: tb/tb_i2c_config_sequencer.sv
// Scoreboard bench for i2c_config_sequencer: a ROM model, an I2C master model
// driven by a per-transaction response plan, and an i2cData monitor.
module tb_i2c_config_sequencer;
  localparam int AW = 8;

  logic clk = 1'b0;
  logic reset = 1'b1;
`ifdef I2C_CONFIG_HPD_REINIT_EN
  logic hotPlug = 1'b0;
`endif

  i2c_config_sequencer_if #(.ADDR_WIDTH(AW)) bus ();

  i2c_config_sequencer #(
    .NUM_ENTRIES(3), .ADDR_WIDTH(AW), .MAX_RETRIES(3),
    .GAP_CYCLES(100), .TIMEOUT_CYCLES(16)
  ) dut (
    .clock50M(clk),
    .reset(reset),
`ifdef I2C_CONFIG_HPD_REINIT_EN
    .hotPlug(hotPlug),
`endif
    .bus(bus)
  );

  always #10 clk = ~clk;

  int          errors = 0;
  int          checks = 0;
  int          cycleCount = 0;
  int          startCount = 0;
  int          startCycle[$];
  logic [23:0] expQ[$];
  int          plan[$];      // 0 = ACK, 1 = NACK, 2 = no response
  int          doneDriveCycle = 0;
  int          injectReq = 0;
  logic [23:0] rom [0:3];

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
    end
  endtask

  always @(posedge clk) cycleCount <= cycleCount + 1;

  // Synchronous ROM: data one clock after address.
  always @(posedge clk) bus.romData <= (bus.romAddr < 8'd4) ? rom[bus.romAddr[1:0]] : 24'h000000;

  // I2C master model.
  initial begin
    int code;
    int injectSeen;
    injectSeen = 0;
    bus.i2cDone = 1'b0;
    bus.i2cAckError = 1'b0;
    forever begin
      @(negedge clk);
      if (injectReq != injectSeen) begin
        injectSeen = injectReq;
        bus.i2cDone = 1'b1;
        @(negedge clk);
        bus.i2cDone = 1'b0;
      end else if (!reset && bus.i2cStart) begin
        code = (plan.size() > 0) ? plan.pop_front() : 0;
        if (code != 2) begin
          repeat (3) @(negedge clk);
          if (!reset) begin
            bus.i2cDone = 1'b1;
            bus.i2cAckError = (code == 1);
            doneDriveCycle = cycleCount;
            @(negedge clk);
            bus.i2cDone = 1'b0;
            bus.i2cAckError = 1'b0;
          end
        end
      end
    end
  end

  // Monitor: every i2cStart pulse must match the next expected command.
  initial begin
    forever begin
      @(negedge clk);
      if (!reset && bus.i2cStart) begin
        startCount++;
        startCycle.push_back(cycleCount);
        check("exp_pending", {31'd0, (expQ.size() > 0)}, 32'd1);
        if (expQ.size() > 0) check("i2cData", {8'd0, bus.i2cData}, {8'd0, expQ.pop_front()});
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic pulseStart();
    @(negedge clk);
    bus.configStart = 1'b1;
    @(negedge clk);
    bus.configStart = 1'b0;
  endtask

  task automatic waitEnd(input string name, input int budget);
    int n;
    n = 0;
    while (!(bus.configDone || bus.configError) && n < budget) begin
      @(negedge clk);
      n++;
    end
    check({name, "_finished"}, {31'd0, (bus.configDone || bus.configError)}, 32'd1);
  endtask

  task automatic waitRomAddr(input logic [AW-1:0] addr, input int budget);
    int n;
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (bus.romAddr != addr && n < budget);
    check("romAddr_reached", {24'd0, bus.romAddr}, {24'd0, addr});
  endtask

  initial begin
    int s0;
    int base;
    int lat;
    int n;
    int fetchCycle;
    bus.configStart = 1'b0;
    rom[0] = 24'h724110; rom[1] = 24'h729803; rom[2] = 24'h72D6C0; rom[3] = 24'h000000;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    check("rst_romAddr", {24'd0, bus.romAddr}, 32'd0);
    check("rst_i2cStart", {31'd0, bus.i2cStart}, 32'd0);
    check("rst_i2cData", {8'd0, bus.i2cData}, 32'd0);
    check("rst_busy", {31'd0, bus.busy}, 32'd0);
    check("rst_done", {31'd0, bus.configDone}, 32'd0);
    check("rst_error", {31'd0, bus.configError}, 32'd0);
    check("rst_errorIndex", {24'd0, bus.errorIndex}, 32'd0);

    // T1: all ACK, latency, ignored configStart, gap length
    s0 = startCount;
    expQ = '{24'h724110, 24'h729803, 24'h72D6C0};
    @(negedge clk);
    bus.configStart = 1'b1;
    lat = 0;
    for (int i = 1; i <= 8; i++) begin
      @(posedge clk);
      #1;
      if (i == 1) bus.configStart = 1'b0;
      if (bus.i2cStart) begin
        lat = i;
        break;
      end
    end
    check("start_latency", lat, 32'd3);
    pulseStart();
    waitRomAddr(8'd1, 400);
    fetchCycle = cycleCount;
    check("gap_to_fetch", fetchCycle - doneDriveCycle, 32'd101);
    waitEnd("t1", 1500);
    check("t1_done", {31'd0, bus.configDone}, 32'd1);
    check("t1_error", {31'd0, bus.configError}, 32'd0);
    check("t1_busy", {31'd0, bus.busy}, 32'd0);
    check("t1_starts", startCount - s0, 32'd3);
    injectReq++;
    repeat (6) @(negedge clk);
    check("stray_done_keeps_done", {31'd0, bus.configDone}, 32'd1);
    check("stray_done_no_start", startCount - s0, 32'd3);

    // T2: end marker at entry 1
    rom[1] = 24'hFF0000;
    s0 = startCount;
    expQ = '{24'h724110};
    pulseStart();
    waitRomAddr(8'd1, 400);
    n = 0;
    while (!bus.configDone && n < 10) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("marker_done_latency", n, 32'd2);
    check("t2_i2cData_marker", {8'd0, bus.i2cData}, 32'h00FF0000);
    check("t2_starts", startCount - s0, 32'd1);
    check("t2_busy", {31'd0, bus.busy}, 32'd0);
    rom[1] = 24'h729803;

    // T3: entry 1 NACKed twice then ACKed
    s0 = startCount;
    plan = '{0, 1, 1, 0, 0};
    expQ = '{24'h724110, 24'h729803, 24'h729803, 24'h729803, 24'h72D6C0};
    pulseStart();
    waitEnd("t3", 2000);
    check("t3_done", {31'd0, bus.configDone}, 32'd1);
    check("t3_error", {31'd0, bus.configError}, 32'd0);
    check("t3_starts", startCount - s0, 32'd5);

    // T4: entry 2 always NACKed
    s0 = startCount;
    plan = '{0, 0, 1, 1, 1, 1};
    expQ = '{24'h724110, 24'h729803, 24'h72D6C0, 24'h72D6C0, 24'h72D6C0, 24'h72D6C0};
    pulseStart();
    waitEnd("t4", 2000);
    check("t4_error", {31'd0, bus.configError}, 32'd1);
    check("t4_done", {31'd0, bus.configDone}, 32'd0);
    check("t4_errorIndex", {24'd0, bus.errorIndex}, 32'd2);
    repeat (300) @(negedge clk);
    check("t4_starts", startCount - s0, 32'd6);
    check("t4_busy", {31'd0, bus.busy}, 32'd0);
    check("t4_exp_left", expQ.size(), 32'd0);

    // T5: master never answers, timeout retries
    s0 = startCount;
    base = startCycle.size();
    plan = '{2, 2, 2, 2};
    expQ = '{24'h724110, 24'h724110, 24'h724110, 24'h724110};
    pulseStart();
    waitEnd("t5", 2000);
    check("t5_error", {31'd0, bus.configError}, 32'd1);
    check("t5_errorIndex", {24'd0, bus.errorIndex}, 32'd0);
    check("t5_starts", startCount - s0, 32'd4);
    if (startCycle.size() >= base + 4) begin
      check("t5_retry_interval", startCycle[base+1] - startCycle[base], 32'd119);
      check("t5_retry_interval_last", startCycle[base+3] - startCycle[base+2], 32'd119);
    end else begin
      check("t5_start_records", startCycle.size() - base, 32'd4);
    end

    // T6: reset while waiting on entry 1, then a clean restart
    s0 = startCount;
    plan = '{0, 2};
    expQ = '{24'h724110, 24'h729803};
    pulseStart();
    n = 0;
    while (startCount < s0 + 2 && n < 500) begin
      @(negedge clk);
      n++;
    end
    check("t6_second_start", startCount - s0, 32'd2);
    repeat (5) @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("t6_rst_i2cStart", {31'd0, bus.i2cStart}, 32'd0);
    check("t6_rst_busy", {31'd0, bus.busy}, 32'd0);
    check("t6_rst_romAddr", {24'd0, bus.romAddr}, 32'd0);
    check("t6_rst_error", {31'd0, bus.configError}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    plan.delete();
    check("t6_exp_left", expQ.size(), 32'd0);
    s0 = startCount;
    expQ = '{24'h724110, 24'h729803, 24'h72D6C0};
    pulseStart();
    waitEnd("t6", 1500);
    check("t6_done", {31'd0, bus.configDone}, 32'd1);
    check("t6_starts", startCount - s0, 32'd3);

`ifdef I2C_CONFIG_HPD_REINIT_EN
    // Hot-plug rising edge while DONE restarts the sequence
    s0 = startCount;
    expQ = '{24'h724110, 24'h729803, 24'h72D6C0};
    @(negedge clk);
    hotPlug = 1'b1;
    n = 0;
    while ((bus.configDone || bus.romAddr != 8'd0) && n < 8) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("hpd_restart_within_4", {31'd0, (n <= 4)}, 32'd1);
    check("hpd_done_cleared", {31'd0, bus.configDone}, 32'd0);
    waitEnd("hpd", 1500);
    check("hpd_done", {31'd0, bus.configDone}, 32'd1);
    check("hpd_starts", startCount - s0, 32'd3);
    hotPlug = 1'b0;
`endif

    repeat (5) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
